// File: rtl/mem_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_line_arbiter
//  Description : Two-port arbiter sharing one line-granular main memory
//                between two cache controllers (port 0 typically the
//                I-cache, port 1 the D-cache). The memory is locked to one
//                requester from arbitration until mem_gnt (or until the
//                owner withdraws its request). Contention is resolved
//                round-robin against the most recently granted port.
//
//  Parameters  : LINE_ADDR_LEN - log2 of 32-bit words per line
//                ADDR_LEN      - line address width (tag + set bits)
//
//  Ports       : clk, rst                     - clock, sync active-high reset
//                pX_rd_req / pX_wr_req        - port X line read / write
//                                               request, held until pX_gnt
//                pX_addr, pX_wr_line          - port X line address / data
//                pX_rd_line                   - read line returned to port X
//                pX_gnt                       - port X transaction complete
//                mem_rd_req / mem_wr_req      - request to main memory
//                mem_addr, mem_wr_line        - address / data to memory
//                mem_rd_line, mem_gnt         - data / completion from memory
//
//  Optional    : define MEM_LINE_ARB_STATS_EN to add the stat_gnt0,
//                stat_gnt1 and stat_conflict 32-bit event counters.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_line_arbiter #(
    parameter int  LINE_ADDR_LEN = 3,
    parameter int  ADDR_LEN      = 9,
    localparam int LW            = 32 << LINE_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                p0_rd_req,
    input  logic                p0_wr_req,
    input  logic [ADDR_LEN-1:0] p0_addr,
    input  logic [LW-1:0]       p0_wr_line,
    output logic [LW-1:0]       p0_rd_line,
    output logic                p0_gnt,

    input  logic                p1_rd_req,
    input  logic                p1_wr_req,
    input  logic [ADDR_LEN-1:0] p1_addr,
    input  logic [LW-1:0]       p1_wr_line,
    output logic [LW-1:0]       p1_rd_line,
    output logic                p1_gnt,

    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [LW-1:0]       mem_wr_line,
    input  logic [LW-1:0]       mem_rd_line,
    input  logic                mem_gnt
`ifdef MEM_LINE_ARB_STATS_EN
    ,
    output logic [31:0]         stat_gnt0,
    output logic [31:0]         stat_gnt1,
    output logic [31:0]         stat_conflict
`endif
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last;          // most recently granted port
    logic [LW-1:0] r_p0_rd_line;
    logic [LW-1:0] r_p1_rd_line;

    logic          w_req0;
    logic          w_req1;
    logic          w_gnt0;
    logic          w_gnt1;

    assign w_req0 = p0_rd_req | p0_wr_req;
    assign w_req1 = p1_rd_req | p1_wr_req;

    // ------------------------------------------------------------------------
    // Memory-side pass-through and grant forwarding.
    // While reset is asserted everything toward memory and toward the caches
    // is forced quiet, so an in-flight transaction is dropped without a
    // grant escaping in the reset cycle itself.
    // A port raising both rd and wr is treated as a write; the read strobe
    // is suppressed so memory never sees both at once.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        if (!rst) begin
            case (r_state)
                OWN0: begin
                    mem_wr_req  = p0_wr_req;
                    mem_rd_req  = p0_rd_req & ~p0_wr_req;
                    mem_addr    = p0_addr;
                    mem_wr_line = p0_wr_line;
                    w_gnt0      = mem_gnt;
                end
                OWN1: begin
                    mem_wr_req  = p1_wr_req;
                    mem_rd_req  = p1_rd_req & ~p1_wr_req;
                    mem_addr    = p1_addr;
                    mem_wr_line = p1_wr_line;
                    w_gnt1      = mem_gnt;
                end
                default: begin
                    // IDLE: memory stays quiet and a stray mem_gnt is dropped
                end
            endcase
        end
    end

    assign p0_gnt = w_gnt0;
    assign p1_gnt = w_gnt1;

    // Read data bypasses the holding register in the grant cycle so the
    // cache can consume it immediately; afterwards the register holds it.
    assign p0_rd_line = w_gnt0 ? mem_rd_line : r_p0_rd_line;
    assign p1_rd_line = w_gnt1 ? mem_rd_line : r_p1_rd_line;

    // ------------------------------------------------------------------------
    // Ownership FSM. Every grant or abort returns through IDLE, which gives
    // the round-robin decision a chance to serve a waiting port between two
    // back-to-back transactions of the same port (write-back then refill).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;   // so port 0 wins the first tie
            r_p0_rd_line <= '0;
            r_p1_rd_line <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // On a tie the port that was not granted last wins
                    if (w_req0 && (!w_req1 || r_last)) begin
                        r_state <= OWN0;
                    end else if (w_req1) begin
                        r_state <= OWN1;
                    end
                end
                OWN0: begin
                    if (mem_gnt) begin
                        r_state      <= IDLE;
                        r_last       <= 1'b0;
                        r_p0_rd_line <= mem_rd_line;
                    end else if (!w_req0) begin
                        // owner withdrew: abort without touching r_last
                        r_state <= IDLE;
                    end
                end
                OWN1: begin
                    if (mem_gnt) begin
                        r_state      <= IDLE;
                        r_last       <= 1'b1;
                        r_p1_rd_line <= mem_rd_line;
                    end else if (!w_req1) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_LINE_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Event counters, free-running modulo 2^32.
    // A conflict cycle is one where a port is made to wait on the other:
    // either the non-owner is requesting, or both request while IDLE.
    // ------------------------------------------------------------------------
    logic w_conflict;

    assign w_conflict = ((r_state == OWN0) && w_req1) ||
                        ((r_state == OWN1) && w_req0) ||
                        ((r_state == IDLE) && w_req0 && w_req1);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_gnt0     <= 32'd0;
            stat_gnt1     <= 32'd0;
            stat_conflict <= 32'd0;
        end else begin
            if (w_gnt0) begin
                stat_gnt0 <= stat_gnt0 + 32'd1;
            end
            if (w_gnt1) begin
                stat_gnt1 <= stat_gnt1 + 32'd1;
            end
            if (w_conflict) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_line_arbiter
//  Description : Self-checking bench for mem_line_arbiter. Requesters push
//                expected transactions into per-port queues; a monitor pops
//                them on every grant and compares routing, data and
//                round-robin order against a line-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_line_arbiter;

    localparam int LINE_ADDR_LEN = 3;
    localparam int ADDR_LEN      = 9;
    localparam int LW            = 32 << LINE_ADDR_LEN;

    typedef struct {
        logic                wr;
        logic [ADDR_LEN-1:0] addr;
        logic [LW-1:0]       data;
    } txn_t;

    logic                clk;
    logic                rst;
    logic                p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
    logic [ADDR_LEN-1:0] p0_addr, p1_addr, mem_addr;
    logic [LW-1:0]       p0_wr_line, p1_wr_line, p0_rd_line, p1_rd_line;
    logic                p0_gnt, p1_gnt;
    logic                mem_rd_req, mem_wr_req, mem_gnt;
    logic [LW-1:0]       mem_wr_line, mem_rd_line;
`ifdef MEM_LINE_ARB_STATS_EN
    logic [31:0]         stat_gnt0, stat_gnt1, stat_conflict;
`endif

    int   checks = 0;
    int   errors = 0;
    txn_t q0[$];
    txn_t q1[$];
    int   gnt_log[$];
    logic [LW-1:0] marr    [0:(1<<ADDR_LEN)-1];   // memory behind the arbiter
    logic [LW-1:0] ref_mem [0:(1<<ADDR_LEN)-1];   // reference line contents
    int   fixed_lat = 0;
    bit   spur_en   = 0;

    mem_line_arbiter #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .ADDR_LEN      (ADDR_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p0_rd_req   (p0_rd_req),
        .p0_wr_req   (p0_wr_req),
        .p0_addr     (p0_addr),
        .p0_wr_line  (p0_wr_line),
        .p0_rd_line  (p0_rd_line),
        .p0_gnt      (p0_gnt),
        .p1_rd_req   (p1_rd_req),
        .p1_wr_req   (p1_wr_req),
        .p1_addr     (p1_addr),
        .p1_wr_line  (p1_wr_line),
        .p1_rd_line  (p1_rd_line),
        .p1_gnt      (p1_gnt),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt)
`ifdef MEM_LINE_ARB_STATS_EN
        ,
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [LW-1:0] init_line(input logic [ADDR_LEN-1:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {8'hA5, 4'(i), 11'h0, a};
        return l;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    // Main-memory responder: grants after a latency, returns the old line
    // contents and commits writes at the grant.
    initial begin
        int cnt;
        int lat;
        mem_gnt     = 1'b0;
        mem_rd_line = '0;
        cnt         = 0;
        lat         = 1;
        forever begin
            @(negedge clk);
            if (mem_gnt) begin
                mem_gnt = 1'b0;
                cnt     = 0;
            end else if (mem_rd_req || mem_wr_req) begin
                if (cnt == 0) lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
                cnt++;
                if (cnt >= lat) begin
                    mem_rd_line = marr[mem_addr];
                    if (mem_wr_req) marr[mem_addr] = mem_wr_line;
                    mem_gnt = 1'b1;
                end
            end else begin
                cnt = 0;
                if (spur_en && $urandom_range(0, 7) == 0) begin
                    mem_rd_line = rand_line();
                    mem_gnt     = 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic          prev_gnt;
        bit            rr_valid;
        int            rr_port;
        logic [LW-1:0] exp_hold [2];
        logic          g;
        logic          oreq;
        logic [LW-1:0] rl;
        logic [LW-1:0] e;
        txn_t          t;
        bit            have;
        prev_gnt    = 1'b0;
        rr_valid    = 0;
        rr_port     = 0;
        exp_hold[0] = '0;
        exp_hold[1] = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                chk("gnt_during_reset", LW'({p1_gnt, p0_gnt}), LW'(0));
                exp_hold[0] = '0;
                exp_hold[1] = '0;
                rr_valid    = 0;
                prev_gnt    = 1'b0;
            end else begin
                if (prev_gnt) begin
                    chk("idle_gap_rd_req", LW'(mem_rd_req), LW'(0));
                    chk("idle_gap_wr_req", LW'(mem_wr_req), LW'(0));
                end
                if (p0_gnt || p1_gnt) chk("gnt_exclusive", LW'(p0_gnt & p1_gnt), LW'(0));
                for (int x = 0; x < 2; x++) begin
                    g    = (x == 0) ? p0_gnt : p1_gnt;
                    rl   = (x == 0) ? p0_rd_line : p1_rd_line;
                    oreq = (x == 0) ? (p1_rd_req | p1_wr_req) : (p0_rd_req | p0_wr_req);
                    if (g) begin
                        have = 0;
                        if (x == 0 && q0.size() > 0) begin t = q0.pop_front(); have = 1; end
                        if (x == 1 && q1.size() > 0) begin t = q1.pop_front(); have = 1; end
                        checks++;
                        if (!have) begin
                            errors++;
                            $display("FAIL unexpected_gnt port %0d: got gnt=1 required gnt=0 (nothing outstanding)", x);
                        end else begin
                            chk("gnt_mem_addr", LW'(mem_addr), LW'(t.addr));
                            chk("gnt_mem_wr_req", LW'(mem_wr_req), LW'(t.wr));
                            chk("gnt_mem_rd_req", LW'(mem_rd_req), LW'(!t.wr));
                            if (t.wr) chk("gnt_mem_wr_line", mem_wr_line, t.data);
                            e = ref_mem[t.addr];
                            chk("gnt_rd_line", rl, e);
                            exp_hold[x] = e;
                            if (t.wr) ref_mem[t.addr] = t.data;
                        end
                        if (rr_valid) chk("round_robin", LW'(x), LW'(rr_port));
                        rr_valid = oreq;
                        rr_port  = 1 - x;
                        gnt_log.push_back(x);
                    end else begin
                        chk("rd_line_hold", rl, exp_hold[x]);
                    end
                end
                prev_gnt = p0_gnt | p1_gnt;
            end
        end
    end

    // Issue one transaction (entered just after a rising edge), wait for its
    // grant, then release the request lines just after the following edge.
    task automatic do_txn(input int port, input logic rd, input logic wr,
                          input logic [ADDR_LEN-1:0] addr, input logic [LW-1:0] data);
        txn_t t;
        int   n;
        bit   got;
        t.wr   = wr;
        t.addr = addr;
        t.data = data;
        if (port == 0) begin
            q0.push_back(t);
            p0_rd_req = rd; p0_wr_req = wr; p0_addr = addr; p0_wr_line = data;
        end else begin
            q1.push_back(t);
            p1_rd_req = rd; p1_wr_req = wr; p1_addr = addr; p1_wr_line = data;
        end
        n   = 0;
        got = 0;
        while (!got && n < 3000) begin
            @(negedge clk); #2;
            got = (port == 0) ? p0_gnt : p1_gnt;
            n++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL gnt_timeout port %0d addr %h: got no gnt in %0d cycles, required gnt", port, addr, n);
        end
        @(posedge clk); #1;
        if (port == 0) begin
            p0_rd_req = 1'b0; p0_wr_req = 1'b0; p0_addr = '0; p0_wr_line = '0;
        end else begin
            p1_rd_req = 1'b0; p1_wr_req = 1'b0; p1_addr = '0; p1_wr_line = '0;
        end
    endtask

    task automatic rand_port(input int port, input int n);
        int kind;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            kind = $urandom_range(0, 5);
            do_txn(port, (kind < 3) || (kind == 5), kind >= 3,
                   ADDR_LEN'(9'h100 + $urandom_range(0, 7)), rand_line());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic chk_order(input string name, input int base, input int n, input int first);
        for (int i = 0; i < n; i++) begin
            if (base + i < gnt_log.size())
                chk(name, LW'(gnt_log[base + i]), LW'((first + i) % 2));
            else
                chk(name, LW'(gnt_log.size()), LW'(base + n));
        end
    endtask

    initial begin
        int            base;
        logic [LW-1:0] d;
`ifdef MEM_LINE_ARB_STATS_EN
        logic [31:0]   s0;
        logic [31:0]   s1;
`endif
        rst = 1'b1;
        p0_rd_req = 1'b0; p0_wr_req = 1'b0; p0_addr = '0; p0_wr_line = '0;
        p1_rd_req = 1'b0; p1_wr_req = 1'b0; p1_addr = '0; p1_wr_line = '0;
        for (int a = 0; a < (1 << ADDR_LEN); a++) begin
            marr[a]    = init_line(ADDR_LEN'(a));
            ref_mem[a] = init_line(ADDR_LEN'(a));
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk); #2;
        chk("rst_mem_rd_req", LW'(mem_rd_req), LW'(0));
        chk("rst_mem_wr_req", LW'(mem_wr_req), LW'(0));
        chk("rst_mem_addr", LW'(mem_addr), LW'(0));
        chk("rst_mem_wr_line", mem_wr_line, LW'(0));
        chk("rst_gnts", LW'({p1_gnt, p0_gnt}), LW'(0));
        chk("rst_p0_rd_line", p0_rd_line, LW'(0));
        chk("rst_p1_rd_line", p1_rd_line, LW'(0));
`ifdef MEM_LINE_ARB_STATS_EN
        chk("rst_stat_gnt0", LW'(stat_gnt0), LW'(0));
        chk("rst_stat_gnt1", LW'(stat_gnt1), LW'(0));
        chk("rst_stat_conflict", LW'(stat_conflict), LW'(0));
`endif

        // Single port-0 read with slow memory
        fixed_lat = 50;
        @(posedge clk); #1;
        fork
            do_txn(0, 1'b1, 1'b0, 9'h05A, '0);
            begin
                @(negedge clk); #2;
                chk("t1_arb_latency", LW'(mem_rd_req), LW'(0));
                @(negedge clk); #2;
                chk("t1_mem_rd_req", LW'(mem_rd_req), LW'(1));
                chk("t1_mem_addr", LW'(mem_addr), LW'(9'h05A));
            end
        join
        chk("t1_rd_line", p0_rd_line, init_line(9'h05A));
        chk("t1_gnt_pulse", LW'(p0_gnt), LW'(0));

        // Simultaneous requests in the first cycle after reset
        fixed_lat = 4;
        do_reset();
        base = gnt_log.size();
        d    = rand_line();
        fork
            do_txn(0, 1'b1, 1'b0, 9'h010, '0);
            do_txn(1, 1'b0, 1'b1, 9'h020, d);
            begin
                @(negedge clk); #2;
                @(negedge clk); #2;
                chk("t2_own0_rd_req", LW'(mem_rd_req), LW'(1));
                chk("t2_own0_wr_req", LW'(mem_wr_req), LW'(0));
                chk("t2_own0_p1_gnt", LW'(p1_gnt), LW'(0));
            end
        join
        chk_order("t2_order", base, 2, 0);

        // Both ports streaming: strict alternation
        fixed_lat = 3;
        base = gnt_log.size();
`ifdef MEM_LINE_ARB_STATS_EN
        s0 = stat_gnt0;
        s1 = stat_gnt1;
`endif
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 3; i++) do_txn(0, 1'b1, 1'b0, ADDR_LEN'(9'h040 + i), '0);
            for (int i = 0; i < 3; i++) do_txn(1, 1'b0, 1'b1, ADDR_LEN'(9'h048 + i), rand_line());
        join
        chk_order("t3_order", base, 6, 0);
`ifdef MEM_LINE_ARB_STATS_EN
        chk("t3_stat_gnt0", LW'(stat_gnt0 - s0), LW'(3));
        chk("t3_stat_gnt1", LW'(stat_gnt1 - s1), LW'(3));
`endif

        // Port 1 write-back then refill, then read the written line back
        fixed_lat = 5;
        d = rand_line();
        @(posedge clk); #1;
        do_txn(1, 1'b0, 1'b1, 9'h1FF, d);
        do_txn(1, 1'b1, 1'b0, 9'h033, '0);
        chk("t4_refill_line", p1_rd_line, init_line(9'h033));
        do_txn(1, 1'b1, 1'b0, 9'h1FF, '0);
        chk("t4_readback_line", p1_rd_line, d);

        // Owner aborts before mem_gnt; round-robin pointer must not move
        fixed_lat = 20;
        @(posedge clk); #1;
        p0_rd_req = 1'b1;
        p0_addr   = 9'h077;
        repeat (3) begin @(posedge clk); #1; end
        p0_rd_req = 1'b0;
        @(negedge clk); #2;
        chk("t5_abort_mem_rd_req", LW'(mem_rd_req), LW'(0));
        begin
            logic seen;
            seen = 1'b0;
            repeat (30) begin @(negedge clk); #2; seen = seen | p0_gnt; end
            chk("t5_abort_no_gnt", LW'(seen), LW'(0));
        end
        fixed_lat = 3;
        base = gnt_log.size();
        @(posedge clk); #1;
        fork
            do_txn(0, 1'b1, 1'b0, 9'h011, '0);
            do_txn(1, 1'b1, 1'b0, 9'h012, '0);
        join
        chk_order("t5_tie_after_abort", base, 2, 0);

        // Reset while port 1 owns memory with a write in flight
        fixed_lat = 20;
        d = rand_line();
        @(posedge clk); #1;
        fork
            do_txn(1, 1'b0, 1'b1, 9'h0AA, d);
            begin repeat (2) begin @(posedge clk); #1; end do_txn(0, 1'b1, 1'b0, 9'h0BB, '0); end
            begin
                repeat (4) begin @(posedge clk); #1; end
                chk("t6_own1_wr_req", LW'(mem_wr_req), LW'(1));
                base = gnt_log.size();
                rst  = 1'b1;
                @(posedge clk); #1;
                rst  = 1'b0;
                @(negedge clk); #2;
                chk("t6_post_rst_rd_req", LW'(mem_rd_req), LW'(0));
                chk("t6_post_rst_wr_req", LW'(mem_wr_req), LW'(0));
                chk("t6_post_rst_p1_gnt", LW'(p1_gnt), LW'(0));
            end
        join
        chk_order("t6_order_after_rst", base, 2, 0);

        // Randomized traffic from both ports, with stray mem_gnt while idle
        fixed_lat = 0;
        spur_en   = 1;
        @(posedge clk); #1;
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        spur_en = 0;
        repeat (3) @(posedge clk);
        chk("q0_drained", LW'(q0.size()), LW'(0));
        chk("q1_drained", LW'(q1.size()), LW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
